// File: rtl/calc1_pkg.sv
// Shared constants, result type and arbitration helpers for the calc1 block.
package calc1_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned NumPorts = 4;
  localparam int unsigned CmdW     = 4;
  localparam int unsigned RespW    = 2;
  localparam int unsigned PortIdxW = 2;

  localparam logic [CmdW-1:0] CmdNop = 4'd0;
  localparam logic [CmdW-1:0] CmdAdd = 4'd1;
  localparam logic [CmdW-1:0] CmdSub = 4'd2;
  localparam logic [CmdW-1:0] CmdSll = 4'd5;
  localparam logic [CmdW-1:0] CmdSrl = 4'd6;

  localparam logic [RespW-1:0] RespNone    = 2'd0;
  localparam logic [RespW-1:0] RespOk      = 2'd1;
  localparam logic [RespW-1:0] RespOvf     = 2'd2;
  localparam logic [RespW-1:0] RespInvalid = 2'd3;

  typedef struct packed {
    logic [RespW-1:0] resp;
    logic [DataW-1:0] data;
  } result_t;

  function automatic logic is_addsub(input logic [CmdW-1:0] cmd);
    return (cmd == CmdAdd) || (cmd == CmdSub);
  endfunction

  function automatic logic is_shift(input logic [CmdW-1:0] cmd);
    return (cmd == CmdSll) || (cmd == CmdSrl);
  endfunction

  // One-hot grant of the first requester at or after ptr (wrapping).
  // ptr = 0 gives plain fixed priority, port 1 highest.
  function automatic logic [NumPorts-1:0] rr_grant(input logic [NumPorts-1:0] req,
                                                   input logic [PortIdxW-1:0] ptr);
    logic [NumPorts-1:0] gnt;
    logic [PortIdxW-1:0] idx;
    logic                found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      idx = ptr + PortIdxW'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [PortIdxW-1:0] onehot_idx(input logic [NumPorts-1:0] oh);
    logic [PortIdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (oh[i]) idx = PortIdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/calc1_port.sv
// One request port: captures cmd/operand1 then operand2, holds the request
// until granted (invalid commands complete on their own) and registers the
// one-cycle response.
module calc1_port
  import calc1_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CmdW-1:0]  cmd_i,
  input  logic [DataW-1:0] data_i,
  output logic             pend_o,
  output logic [CmdW-1:0]  cmd_o,
  output logic [DataW-1:0] op1_o,
  output logic [DataW-1:0] op2_o,
  input  logic             gnt_i,
  input  result_t          res_i,
  output result_t          out_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOp2  = 2'd1;
  localparam logic [1:0] StPend = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CmdW-1:0]  cmd_q, cmd_d;
  logic [DataW-1:0] op1_q, op1_d;
  logic [DataW-1:0] op2_q, op2_d;
  result_t          out_q, out_d;
  logic             valid_cmd;

  assign valid_cmd = is_addsub(cmd_q) || is_shift(cmd_q);

  // Next state: capture, wait for grant, and build the one-cycle response.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    out_d   = '{resp: RespNone, data: '0};
    case (state_q)
      StIdle: begin
        if (cmd_i != CmdNop) begin
          cmd_d   = cmd_i;
          op1_d   = data_i;
          state_d = StOp2;
        end
      end
      StOp2: begin
        op2_d   = data_i;
        state_d = StPend;
      end
      StPend: begin
        if (!valid_cmd) begin
          out_d.resp = RespInvalid;
          state_d    = StIdle;
        end else if (gnt_i) begin
          out_d.resp = res_i.resp;
          out_d.data = (res_i.resp == RespOk) ? res_i.data : '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and response registers; reset drops any in-flight command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cmd_q   <= CmdNop;
      op1_q   <= '0;
      op2_q   <= '0;
      out_q   <= '{resp: RespNone, data: '0};
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      out_q   <= out_d;
    end
  end

  // Only valid commands compete for a unit.
  assign pend_o = (state_q == StPend) && valid_cmd;
  assign cmd_o  = cmd_q;
  assign op1_o  = op1_q;
  assign op2_o  = op2_q;
  assign out_o  = out_q;

endmodule

// File: rtl/calc1_top.sv
// Four-port calculator: shared add/sub unit and shared shift unit, each with
// its own arbiter. Define CALC1_FAIR_ARB_EN for round-robin arbitration;
// otherwise fixed priority, port 1 highest.
module calc1_top
  import calc1_pkg::*;
(
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4,
  input  logic        a_clk,
  input  logic        b_clk,
  input  logic        scan_in,
  output logic        scan_out,
  input  logic [0:3]  error_found
);

  logic rst;
  assign rst = |reset;

  // Scan and fault-injection inputs have no function here.
  logic unused_scan;
  assign unused_scan = ^{a_clk, b_clk, scan_in, error_found};
  assign scan_out    = 1'b0;

  logic [CmdW-1:0]     cmd_in  [NumPorts];
  logic [DataW-1:0]    data_in [NumPorts];
  logic [CmdW-1:0]     p_cmd   [NumPorts];
  logic [DataW-1:0]    p_op1   [NumPorts];
  logic [DataW-1:0]    p_op2   [NumPorts];
  result_t             p_res   [NumPorts];
  result_t             p_out   [NumPorts];
  logic [NumPorts-1:0] p_pend, p_gnt, as_req, sh_req, as_gnt, sh_gnt;

  // MSB-first port vectors map value-preserving onto [N-1:0] internals.
  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    calc1_port u_port (
      .clk_i  (c_clk),
      .rst_i  (rst),
      .cmd_i  (cmd_in[i]),
      .data_i (data_in[i]),
      .pend_o (p_pend[i]),
      .cmd_o  (p_cmd[i]),
      .op1_o  (p_op1[i]),
      .op2_o  (p_op2[i]),
      .gnt_i  (p_gnt[i]),
      .res_i  (p_res[i]),
      .out_o  (p_out[i])
    );
    assign as_req[i] = p_pend[i] && is_addsub(p_cmd[i]);
    assign sh_req[i] = p_pend[i] && is_shift(p_cmd[i]);
    assign p_gnt[i]  = as_gnt[i] | sh_gnt[i];
  end

`ifdef CALC1_FAIR_ARB_EN
  logic [PortIdxW-1:0] as_ptr_q, as_ptr_d, sh_ptr_q, sh_ptr_d;

  assign as_gnt = rr_grant(as_req, as_ptr_q);
  assign sh_gnt = rr_grant(sh_req, sh_ptr_q);

  // Pointers move to the port after the last one granted.
  always_comb begin
    as_ptr_d = as_ptr_q;
    sh_ptr_d = sh_ptr_q;
    if (|as_gnt) as_ptr_d = onehot_idx(as_gnt) + 2'd1;
    if (|sh_gnt) sh_ptr_d = onehot_idx(sh_gnt) + 2'd1;
  end

  // Round-robin pointer registers, reset to port 1.
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      as_ptr_q <= '0;
      sh_ptr_q <= '0;
    end else begin
      as_ptr_q <= as_ptr_d;
      sh_ptr_q <= sh_ptr_d;
    end
  end
`else
  assign as_gnt = rr_grant(as_req, '0);
  assign sh_gnt = rr_grant(sh_req, '0);
`endif

  logic [CmdW-1:0]  as_cmd, sh_cmd;
  logic [DataW-1:0] as_a, as_b, sh_a, sh_b;
  logic [DataW:0]   as_sum;
  result_t          as_res, sh_res;

  // Route the granted port's operands to each shared unit.
  always_comb begin
    as_cmd = CmdNop;
    as_a   = '0;
    as_b   = '0;
    sh_cmd = CmdNop;
    sh_a   = '0;
    sh_b   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (as_gnt[i]) begin
        as_cmd = p_cmd[i];
        as_a   = p_op1[i];
        as_b   = p_op2[i];
      end
      if (sh_gnt[i]) begin
        sh_cmd = p_cmd[i];
        sh_a   = p_op1[i];
        sh_b   = p_op2[i];
      end
    end
  end

  // Add/sub unit: carry out or borrow reports overflow with zero data.
  always_comb begin
    as_sum = {1'b0, as_a} + {1'b0, as_b};
    as_res = '{resp: RespOk, data: '0};
    if (as_cmd == CmdSub) begin
      if (as_b > as_a) as_res.resp = RespOvf;
      else             as_res.data = as_a - as_b;
    end else if (as_sum[DataW]) begin
      as_res.resp = RespOvf;
    end else begin
      as_res.data = as_sum[DataW-1:0];
    end
  end

  // Shift unit: amount is the low five bits of operand 2, zero fill.
  always_comb begin
    sh_res.resp = RespOk;
    sh_res.data = (sh_cmd == CmdSll) ? (sh_a << sh_b[4:0]) : (sh_a >> sh_b[4:0]);
  end

  // A port holds one command, so at most one unit grants it per cycle.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      p_res[i] = as_gnt[i] ? as_res : sh_res;
    end
  end

  assign out_data1 = p_out[0].data;
  assign out_resp1 = p_out[0].resp;
  assign out_data2 = p_out[1].data;
  assign out_resp2 = p_out[1].resp;
  assign out_data3 = p_out[2].data;
  assign out_resp3 = p_out[2].resp;
  assign out_data4 = p_out[3].data;
  assign out_resp4 = p_out[3].resp;

endmodule

// File: tb/tb_calc1_top.sv
// Scoreboard bench for calc1_top: stimulus pushes expected (cycle, resp, data)
// per port; a negedge monitor pops and compares whenever a response appears.
module tb_calc1_top;

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic [6:0]  rst_v;
  logic [3:0]  cmd [4];
  logic [31:0] din [4];
  logic [31:0] od  [4];
  logic [1:0]  orsp [4];
  logic        scan_out;
  int          cyc;
  int          nchk;
  int          nerr;
  exp_t        exp_q [4][$];
  exp_t        e;

  calc1_top dut (
    .c_clk        (clk),
    .reset        (rst_v),
    .req1_cmd_in  (cmd[0]),
    .req1_data_in (din[0]),
    .req2_cmd_in  (cmd[1]),
    .req2_data_in (din[1]),
    .req3_cmd_in  (cmd[2]),
    .req3_data_in (din[2]),
    .req4_cmd_in  (cmd[3]),
    .req4_data_in (din[3]),
    .out_data1    (od[0]),
    .out_resp1    (orsp[0]),
    .out_data2    (od[1]),
    .out_resp2    (orsp[1]),
    .out_data3    (od[2]),
    .out_resp3    (orsp[2]),
    .out_data4    (od[3]),
    .out_resp4    (orsp[3]),
    .a_clk        (1'b0),
    .b_clk        (1'b0),
    .scan_in      (1'b0),
    .scan_out     (scan_out),
    .error_found  (4'hF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input int at, input logic [1:0] r, input logic [31:0] d);
    exp_q[p].push_back('{cyc: at, resp: r, data: d});
  endtask

  // Two-cycle issue on one port; response expected three cycles after the cmd.
  task automatic send(input int p, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                      input bit want);
    if (want) push(p, cyc + 3, er, ed);
    cmd[p] = c;
    din[p] = a;
    step(1);
    cmd[p] = 4'd0;
    din[p] = b;
    step(1);
    din[p] = '0;
  endtask

  // Monitor: every visible response must match the head of its port's queue.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (orsp[p] != 2'd1) chk($sformatf("p%0d_data_zero", p + 1), od[p], 32'd0);
      if (orsp[p] != 2'd0) begin
        if (exp_q[p].size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL p%0d_unexpected got resp=%0d data=%h want none (cycle %0d)",
                   p + 1, orsp[p], od[p], cyc);
        end else begin
          e = exp_q[p].pop_front();
          chk($sformatf("p%0d_cycle", p + 1), cyc, e.cyc);
          chk($sformatf("p%0d_resp", p + 1), {30'd0, orsp[p]}, {30'd0, e.resp});
          chk($sformatf("p%0d_data", p + 1), od[p], e.data);
        end
      end
    end
  end

  int k;
  int ofs [4];

  initial begin
    nchk = 0;
    nerr = 0;
    rst_v = 7'h7F;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = '0;
    end
    // Commands driven during reset must be ignored.
    cmd[0] = 4'd1;
    din[0] = 32'd5;
    step(3);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_p%0d_resp", p + 1), {30'd0, orsp[p]}, 32'd0);
      chk($sformatf("rst_p%0d_data", p + 1), od[p], 32'd0);
    end
    chk("scan_out", {31'd0, scan_out}, 32'd0);
    cmd[0] = 4'd0;
    din[0] = '0;
    rst_v = '0;
    step(1);

    // Port 1 add, then a second add issued in the first one's response cycle.
    send(0, 4'd1, 32'h5, 32'h7, 2'd1, 32'h0000000C, 1'b1);
    step(1);
    send(0, 4'd1, 32'h10, 32'h20, 2'd1, 32'h00000030, 1'b1);
    step(3);

    // Port 2 add overflow and subtract cases.
    send(1, 4'd1, 32'hFFFFFFFF, 32'h1, 2'd2, 32'h0, 1'b1);
    step(2);
    send(1, 4'd2, 32'h3, 32'h5, 2'd2, 32'h0, 1'b1);
    step(2);
    send(1, 4'd2, 32'h5, 32'h5, 2'd1, 32'h0, 1'b1);
    step(2);
    send(1, 4'd2, 32'h9, 32'h4, 2'd1, 32'h5, 1'b1);
    step(3);

    // Port 3 shifts; 0x24 keeps only amount 4.
    send(2, 4'd5, 32'h1, 32'h1F, 2'd1, 32'h80000000, 1'b1);
    step(2);
    send(2, 4'd6, 32'h80000000, 32'h24, 2'd1, 32'h08000000, 1'b1);
    step(3);

    // All four ports add together; last add/sub grant so far was port 2.
`ifdef CALC1_FAIR_ARB_EN
    ofs = '{2, 3, 0, 1};
`else
    ofs = '{0, 1, 2, 3};
`endif
    k = cyc;
    for (int p = 0; p < 4; p++) begin
      push(p, k + 3 + ofs[p], 2'd1, 32'd101 + 32'(p));
      cmd[p] = 4'd1;
      din[p] = 32'd1 + 32'(p);
    end
    step(1);
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'd100;
    end
    step(1);
    for (int p = 0; p < 4; p++) din[p] = '0;
    step(6);

    // Add/sub and shift grants in the same cycle respond together.
    k = cyc;
    push(0, k + 3, 2'd1, 32'd5);
    push(1, k + 3, 2'd1, 32'd12);
    cmd[0] = 4'd1;
    din[0] = 32'd2;
    cmd[1] = 4'd5;
    din[1] = 32'd3;
    step(1);
    cmd[0] = 4'd0;
    din[0] = 32'd3;
    cmd[1] = 4'd0;
    din[1] = 32'd2;
    step(1);
    din[0] = '0;
    din[1] = '0;
    step(3);

    // Invalid command on port 4; commands while busy are dropped.
    k = cyc;
    push(3, k + 3, 2'd3, 32'd0);
    cmd[3] = 4'd3;
    din[3] = 32'h1234;
    step(1);
    cmd[3] = 4'd1;
    din[3] = 32'h5678;
    step(1);
    cmd[3] = 4'd1;
    din[3] = 32'h9;
    step(1);
    cmd[3] = 4'd0;
    din[3] = '0;
    step(5);

    // Reset two cycles after the cmd: the add must never respond.
    send(0, 4'd1, 32'h11, 32'h22, 2'd1, 32'h33, 1'b0);
    rst_v = 7'b0000001;
    step(1);
    chk("midrst_p1_resp", {30'd0, orsp[0]}, 32'd0);
    chk("midrst_p1_data", od[0], 32'd0);
    rst_v = '0;
    step(4);

    // After reset the arbiter pointer is back at port 1 in either mode.
    k = cyc;
    for (int p = 0; p < 4; p++) begin
      push(p, k + 3 + p, 2'd1, 32'h200 + 32'(p));
      cmd[p] = 4'd1;
      din[p] = 32'h100 + 32'(p);
    end
    step(1);
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'h100;
    end
    step(1);
    for (int p = 0; p < 4; p++) din[p] = '0;
    step(10);

    for (int p = 0; p < 4; p++) begin
      chk($sformatf("p%0d_leftover", p + 1), 32'(exp_q[p].size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
